fod_mmd_seq: RTL and testbench
==============================

Name: fod_mmd_seq

Overview:
- Consumer end of the FOD control-word interface.
- Takes per-period control words (MMD modulus, retimer select, DTC code) and runs the multi-modulus divider as a down-counter on the fast PLL clock.
- Emits one divided pulse per period, with the matching retimer select and DTC code held stable alongside it.
- Fetches words one period ahead through a request/valid handshake, using a one-entry shadow buffer.

Parameters:
- MMD_W, 6, modulus width; legal modulus range MMD_MIN..2^MMD_W-1.
- DTC_W, 10, DTC code width.
- MMD_MIN, 4, smallest legal modulus; smaller requests are clamped to it.

Ports:
- CLK  in  1  PLL clock; all logic is on its rising edge.
- NRST  in  1  synchronous active-low reset.
- EN  in  1  sequencer enable.
- MMD_DCW  in  MMD_W  requested modulus for one output period.
- RT_DCW  in  1  retimer select: 0 = posedge, 1 = negedge.
- DTC_DCW  in  DTC_W  DTC code for the period.
- DCW_VLD  in  1  word valid; sampled only while DCW_REQ=1.
- DCW_REQ  out  1  request for the next word.
- DIV_OUT  out  1  one-cycle pulse at terminal count.
- RT_SEL  out  1  retimer select of the active period.
- DTC_CODE  out  DTC_W  DTC code of the active period.
- CLAMP_ERR  out  1  sticky flag: a modulus below MMD_MIN was received.
- UNDERRUN  out  1  sticky flag: terminal count reached with no next word.

Behaviour:
- Reset (NRST=0 at a rising edge): all registers and outputs go to 0, state goes to IDLE, shadow is emptied. Reset wins over every other event, including mid-period.
- States: IDLE, LOAD, COUNT.
  - IDLE: outputs 0. When EN=1, go to LOAD.
  - LOAD: DCW_REQ=1. On an edge with DCW_VLD=1, the word loads straight into the active register, cnt <= M-1, and the state goes to COUNT.
  - COUNT: cnt decrements by 1 every cycle.
- DIV_OUT is decoded from registers: state==COUNT and cnt==0. Pulse period is therefore exactly M cycles per word. The first pulse comes M cycles after the capture edge.
- RT_SEL and DTC_CODE equal the active-word fields. They change only on the edge that loads the active register, so they are stable across the whole period including its DIV_OUT cycle.
- Handshake:
  - DCW_REQ is a level. It rises the cycle after the active register loads (from LOAD or from a terminal-count reload).
  - It falls the cycle after an edge where DCW_REQ=1 and DCW_VLD=1; that edge captures the word into the shadow register.
  - DCW_VLD while DCW_REQ=0 is ignored.
- Terminal count (cnt==0 edge):
  - Shadow full: active <= shadow, cnt <= M_shadow-1, shadow empties, DCW_REQ goes high next cycle.
  - Shadow empty and DCW_VLD=1 with DCW_REQ=1 on the same edge: bypass. The new word loads into active directly; no underrun.
  - Shadow empty and no valid word: the active word repeats, UNDERRUN is set, DCW_REQ stays high.
- Modulus clamp: an effective M below MMD_MIN becomes MMD_MIN. The clamp is applied at capture and sets CLAMP_ERR. M=0 is clamped the same way.
- EN=0 in LOAD or COUNT: go to IDLE on the next edge, drop DIV_OUT and DCW_REQ, clear shadow and cnt. Sticky flags hold.
- Sticky flags clear only on reset.
- There is no combinational path from any input to any output.

Decomposition:
- Shared package fod_pkg:
  - constants WI=6, DTC_W=10, MMD_MIN=4;
  - typedef fod_dcw_t (mmd, rt, dtc);
  - state enum fod_seq_state_t.
- One sub-module: fod_dcw_shadow, a one-entry skid buffer holding word plus full flag, with capture, pop and bypass ports.

Test Plan:
- Reset release, then EN=1, supply M=8 on each request -> first DIV_OUT 8 cycles after capture, then every 8 cycles; DCW_REQ pulses once per period.
- Alternate M=8/9 with RT=0/1 and DTC=100/200 -> DIV_OUT gaps of 8,9,8,...; RT_SEL/DTC_CODE switch on the edge after each pulse and match the word.
- Withhold DCW_VLD for one period with M=6 -> active word repeats (gap 6), UNDERRUN=1, normal operation resumes after VLD.
- Raise DCW_VLD exactly on the terminal-count edge with shadow empty -> bypass load, next gap equals the new M, UNDERRUN stays 0.
- Send M=2, then M=0 -> gaps of 4, CLAMP_ERR=1.
- NRST=0 for one cycle mid-period (cnt=3) -> next cycle all outputs 0, state IDLE. Separately, EN=0 mid-period -> IDLE, DIV_OUT suppressed, flags retained.

Source files
------------

// File: rtl/fod_pkg.sv
// fod_pkg: shared definitions for the FOD control-word sequencer.
//   WI       - MMD modulus width
//   DTC_W    - DTC code width
//   MMD_MIN  - smallest legal modulus; smaller requests are clamped up to it
//   fod_dcw_t       - one per-period control word (modulus, retimer select, DTC code)
//   fod_seq_state_t - sequencer states
package fod_pkg;

  localparam int WI      = 6;
  localparam int DTC_W   = 10;
  localparam int MMD_MIN = 4;

  typedef struct packed {
    logic [WI-1:0]    mmd;
    logic             rt;
    logic [DTC_W-1:0] dtc;
  } fod_dcw_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_LOAD  = 2'd1,
    SEQ_COUNT = 2'd2
  } fod_seq_state_t;

endpackage

// File: rtl/fod_mmd_seq_if.sv
// fod_mmd_seq_if: control-word request/valid handshake between a word
// producer (master) and the MMD sequencer (slave).
//   MMD_DCW  - requested modulus for one output period
//   RT_DCW   - retimer select (0 = posedge, 1 = negedge)
//   DTC_DCW  - DTC code for the period
//   DCW_VLD  - word valid, only meaningful while DCW_REQ is high
//   DCW_REQ  - level request from the sequencer for its next word
interface fod_mmd_seq_if #(
  parameter int MMD_W = fod_pkg::WI,
  parameter int DTC_W = fod_pkg::DTC_W
);

  logic [MMD_W-1:0] MMD_DCW;
  logic             RT_DCW;
  logic [DTC_W-1:0] DTC_DCW;
  logic             DCW_VLD;
  logic             DCW_REQ;

  modport master (
    output MMD_DCW, RT_DCW, DTC_DCW, DCW_VLD,
    input  DCW_REQ
  );

  modport slave (
    input  MMD_DCW, RT_DCW, DTC_DCW, DCW_VLD,
    output DCW_REQ
  );

endinterface

// File: rtl/fod_dcw_shadow.sv
// fod_dcw_shadow: one-entry skid buffer that holds the prefetched control
// word for the next output period.
//   CLK, NRST - clock, synchronous active-low reset
//   flush     - empty the buffer (sequencer disabled)
//   cap       - an accepted word is presented on in_word this cycle
//   pop       - the active period ends this cycle and wants the next word
//   in_word   - incoming (already clamped) control word
//   full      - buffer holds a word
//   bypass    - buffer empty while a word arrives on the popping edge; the
//               incoming word goes straight to the consumer
//   head      - word the consumer loads on a pop (stored or bypassed)
module fod_dcw_shadow
  import fod_pkg::*;
(
  input  logic     CLK,
  input  logic     NRST,
  input  logic     flush,
  input  logic     cap,
  input  logic     pop,
  input  fod_dcw_t in_word,
  output logic     full,
  output logic     bypass,
  output fod_dcw_t head
);

  fod_dcw_t store;

  // A pop always leaves the buffer empty: either the stored word leaves, or
  // the buffer was empty and any arriving word is bypassed instead of stored.
  always_ff @(posedge CLK) begin
    if (!NRST || flush) begin
      full  <= 1'b0;
      store <= '0;
    end else if (pop) begin
      full <= 1'b0;
    end else if (cap && !full) begin
      store <= in_word;
      full  <= 1'b1;
    end
  end

  assign bypass = cap && pop && !full;
  assign head   = full ? store : in_word;

endmodule

// File: rtl/fod_mmd_seq.sv
// fod_mmd_seq: consumer end of the FOD control-word interface. Runs the
// multi-modulus divider as a down-counter on the PLL clock, one control word
// per output period, prefetching the next word through a one-entry shadow.
//   CLK        - PLL clock, all logic on its rising edge
//   NRST       - synchronous active-low reset
//   EN         - sequencer enable
//   dcw        - control-word handshake (slave side)
//   DIV_OUT    - one-cycle pulse at terminal count
//   RT_SEL     - retimer select of the active period
//   DTC_CODE   - DTC code of the active period
//   CLAMP_ERR  - sticky: a modulus below MMD_MIN was received
//   UNDERRUN   - sticky: terminal count reached with no next word available
module fod_mmd_seq #(
  parameter int MMD_W   = fod_pkg::WI,
  parameter int DTC_W   = fod_pkg::DTC_W,
  parameter int MMD_MIN = fod_pkg::MMD_MIN
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             EN,
  fod_mmd_seq_if.slave     dcw,
  output logic             DIV_OUT,
  output logic             RT_SEL,
  output logic [DTC_W-1:0] DTC_CODE,
  output logic             CLAMP_ERR,
  output logic             UNDERRUN
);

  import fod_pkg::*;

  localparam logic [MMD_W-1:0] MMD_FLOOR = MMD_W'(MMD_MIN);
  localparam logic [MMD_W-1:0] ONE       = MMD_W'(1);

  fod_seq_state_t   state;
  fod_seq_state_t   state_nxt;
  logic [MMD_W-1:0] cnt;
  fod_dcw_t         act;
  fod_dcw_t         in_word;
  fod_dcw_t         sh_head;
  logic             req_q;
  logic             accept;
  logic             tc;
  logic             raw_low;
  logic             sh_full;
  logic             sh_bypass;
  logic             sh_cap;
  logic             sh_pop;
  logic             sh_flush;

  assign raw_low = (dcw.MMD_DCW < MMD_FLOOR);
  assign accept  = req_q && dcw.DCW_VLD;
  assign tc      = (state == SEQ_COUNT) && (cnt == '0);

  // Incoming word with the modulus clamped, so every stored or loaded word
  // is already legal and the counter never sees a modulus below MMD_MIN.
  always_comb begin
    in_word     = '0;
    in_word.mmd = raw_low ? MMD_FLOOR : dcw.MMD_DCW;
    in_word.rt  = dcw.RT_DCW;
    in_word.dtc = dcw.DTC_DCW;
  end

  // Words accepted during LOAD go straight to the active register; only
  // words accepted while counting are offered to the shadow.
  assign sh_cap   = EN && accept && (state == SEQ_COUNT);
  assign sh_pop   = EN && tc;
  assign sh_flush = !EN;

  fod_dcw_shadow u_shadow (
    .CLK     (CLK),
    .NRST    (NRST),
    .flush   (sh_flush),
    .cap     (sh_cap),
    .pop     (sh_pop),
    .in_word (in_word),
    .full    (sh_full),
    .bypass  (sh_bypass),
    .head    (sh_head)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!NRST) state <= SEQ_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; dropping EN returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SEQ_IDLE:  if (EN) state_nxt = SEQ_LOAD;
      SEQ_LOAD: begin
        if (!EN)         state_nxt = SEQ_IDLE;
        else if (accept) state_nxt = SEQ_COUNT;
      end
      SEQ_COUNT: if (!EN) state_nxt = SEQ_IDLE;
      default:   state_nxt = SEQ_IDLE;
    endcase
  end

  // Active word, period counter and request level. At terminal count the
  // next word comes from the shadow (or bypass); with neither available the
  // active word simply runs another period. The request is re-raised on
  // every reload, because the shadow is always empty afterwards.
  always_ff @(posedge CLK) begin
    if (!NRST || !EN) begin
      act   <= '0;
      cnt   <= '0;
      req_q <= 1'b0;
    end else begin
      unique case (state)
        SEQ_IDLE: req_q <= 1'b1;
        SEQ_LOAD: begin
          if (accept) begin
            act <= in_word;
            cnt <= in_word.mmd - ONE;
          end
        end
        SEQ_COUNT: begin
          if (cnt == '0) begin
            req_q <= 1'b1;
            if (sh_full || sh_bypass) begin
              act <= sh_head;
              cnt <= sh_head.mmd - ONE;
            end else begin
              cnt <= act.mmd - ONE;
            end
          end else begin
            cnt <= cnt - ONE;
            if (accept) req_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky error flags; only reset clears them, EN has no effect.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      CLAMP_ERR <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      if (EN && accept && raw_low)          CLAMP_ERR <= 1'b1;
      if (sh_pop && !sh_full && !sh_bypass) UNDERRUN  <= 1'b1;
    end
  end

  // Outputs are decoded from registers only.
  always_comb begin
    DIV_OUT     = tc;
    dcw.DCW_REQ = req_q;
    RT_SEL      = act.rt;
    DTC_CODE    = act.dtc;
  end

endmodule

// File: tb/tb_fod_mmd_seq.sv
// tb_fod_mmd_seq: randomized and directed stimulus for fod_mmd_seq, checked
// every cycle against a period/queue level reference model.
module tb_fod_mmd_seq;

  typedef struct packed {
    logic [5:0] mmd;
    logic       rt;
    logic [9:0] dtc;
  } word_t;

  logic       CLK = 1'b0;
  logic       NRST;
  logic       EN;
  logic       DIV_OUT;
  logic       RT_SEL;
  logic [9:0] DTC_CODE;
  logic       CLAMP_ERR;
  logic       UNDERRUN;

  fod_mmd_seq_if dcw();

  fod_mmd_seq dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .EN        (EN),
    .dcw       (dcw),
    .DIV_OUT   (DIV_OUT),
    .RT_SEL    (RT_SEL),
    .DTC_CODE  (DTC_CODE),
    .CLAMP_ERR (CLAMP_ERR),
    .UNDERRUN  (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: m_state 0 = idle, 1 = waiting for first word,
  // 2 = running. m_phase counts cycles elapsed in the current period.
  int    m_state    = 0;
  int    m_phase    = 0;
  int    m_accepts  = 0;
  word_t m_cur      = '0;
  word_t m_pend[$];
  bit    m_req      = 1'b0;
  bit    m_under    = 1'b0;
  bit    m_clamp    = 1'b0;
  int    gap_since  = 0;
  int    last_gap   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic word_t mkWord(input int m, input bit rt, input int dtc);
    word_t w;
    w.mmd = 6'(m);
    w.rt  = rt;
    w.dtc = 10'(dtc);
    return w;
  endfunction

  function automatic bit modelTerminal();
    return (m_state == 2) && (m_phase == int'(m_cur.mmd) - 1);
  endfunction

  task automatic modelStep(input bit nrst, input bit en, input bit vld, input word_t w);
    word_t wc;
    bit    acc;
    wc  = w;
    if (w.mmd < 6'd4) wc.mmd = 6'd4;
    acc = m_req && vld;
    if (!nrst) begin
      m_state = 0; m_phase = 0; m_cur = '0; m_pend.delete();
      m_req = 1'b0; m_under = 1'b0; m_clamp = 1'b0;
    end else if (m_state != 0 && !en) begin
      m_state = 0; m_phase = 0; m_cur = '0; m_pend.delete(); m_req = 1'b0;
    end else begin
      if (acc && w.mmd < 6'd4) m_clamp = 1'b1;
      case (m_state)
        0: if (en) begin m_state = 1; m_req = 1'b1; end
        1: if (acc) begin m_cur = wc; m_phase = 0; m_state = 2; m_accepts++; end
        default: begin
          if (modelTerminal()) begin
            m_phase = 0;
            m_req   = 1'b1;
            if (m_pend.size() > 0) m_cur = m_pend.pop_front();
            else if (acc) begin m_cur = wc; m_accepts++; end
            else m_under = 1'b1;
          end else begin
            m_phase++;
            if (acc) begin m_pend.push_back(wc); m_req = 1'b0; m_accepts++; end
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // compare every output half a cycle later.
  task automatic applyStimulus(input bit nrst, input bit en, input bit vld, input word_t w);
    NRST        = nrst;
    EN          = en;
    dcw.DCW_VLD = vld;
    dcw.MMD_DCW = w.mmd;
    dcw.RT_DCW  = w.rt;
    dcw.DTC_DCW = w.dtc;
    modelStep(nrst, en, vld, w);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("div_out",   DIV_OUT,     modelTerminal());
    checkOutput("dcw_req",   dcw.DCW_REQ, m_req);
    checkOutput("rt_sel",    RT_SEL,      m_cur.rt);
    checkOutput("dtc_code",  DTC_CODE,    m_cur.dtc);
    checkOutput("clamp_err", CLAMP_ERR,   m_clamp);
    checkOutput("underrun",  UNDERRUN,    m_under);
    if (DIV_OUT) begin last_gap = gap_since; gap_since = 1; end
    else gap_since++;
  endtask

  initial begin
    bit    found;
    word_t w;

    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, mkWord(8, 0, 0));
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, mkWord(8, 0, 0));

    $display("[TB] constant modulus 8");
    for (int i = 0; i < 40; i++) applyStimulus(1, 1, 1, mkWord(8, 0, 55));
    checkOutput("gap_m8", last_gap, 8);

    $display("[TB] alternating 8/9");
    for (int i = 0; i < 60; i++)
      applyStimulus(1, 1, 1, (m_accepts % 2 == 0) ? mkWord(8, 0, 100) : mkWord(9, 1, 200));

    $display("[TB] underrun with modulus 6");
    for (int i = 0; i < 14; i++) applyStimulus(1, 1, 1, mkWord(6, 0, 300));
    for (int i = 0; i < 14; i++) applyStimulus(1, 1, 0, mkWord(6, 0, 300));
    checkOutput("underrun_set", UNDERRUN, 1);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1, mkWord(6, 1, 301));

    $display("[TB] bypass on terminal count");
    applyStimulus(0, 0, 0, mkWord(7, 0, 0));
    applyStimulus(1, 1, 0, mkWord(7, 0, 0));
    applyStimulus(1, 1, 1, mkWord(7, 0, 70));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (modelTerminal()) begin
        applyStimulus(1, 1, 1, mkWord(5, 1, 500));
        found = 1'b1;
      end else begin
        applyStimulus(1, 1, 0, mkWord(7, 0, 70));
      end
    end
    checkOutput("bypass_window", found, 1);
    checkOutput("bypass_dtc", DTC_CODE, 500);
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, mkWord(5, 1, 500));
    checkOutput("gap_bypass", last_gap, 5);
    checkOutput("bypass_no_underrun", UNDERRUN, 0);

    $display("[TB] modulus clamp");
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, mkWord(2, 0, 20));
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, mkWord(0, 1, 21));
    checkOutput("clamp_gap", last_gap, 4);
    checkOutput("clamp_flag", CLAMP_ERR, 1);

    $display("[TB] reset mid-period");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_state == 2 && int'(m_cur.mmd) - 1 - m_phase == 3) begin
        applyStimulus(0, 1, 1, mkWord(4, 0, 9));
        found = 1'b1;
      end else begin
        applyStimulus(1, 1, 1, mkWord(4, 0, 9));
      end
    end
    checkOutput("reset_window", found, 1);
    checkOutput("reset_div", DIV_OUT, 0);
    checkOutput("reset_req", dcw.DCW_REQ, 0);
    checkOutput("reset_clamp", CLAMP_ERR, 0);

    $display("[TB] enable drop mid-period");
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, mkWord(8, 1, 800));
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, mkWord(8, 1, 800));
    for (int i = 0; i < 4; i++)  applyStimulus(1, 1, 1, mkWord(8, 1, 801));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_state == 2 && m_phase == 3) found = 1'b1;
      else applyStimulus(1, 1, 1, mkWord(8, 1, 801));
    end
    checkOutput("en_window", found, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, mkWord(8, 1, 801));
    checkOutput("en_off_div", DIV_OUT, 0);
    checkOutput("en_off_dtc", DTC_CODE, 0);
    checkOutput("en_off_underrun", UNDERRUN, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      w.mmd = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
      w.rt  = 1'($urandom_range(0, 1));
      w.dtc = 10'($urandom_range(0, 1023));
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 199) != 0,
                    $urandom_range(0, 3) != 0, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
